pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_pkg.sv | 15 +
 rtl/edge_tick.sv | 26 ++
 rtl/pwm_gen.sv | 101 ++++++++++
 tb/tb_pwm_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM generator.
package pwm_pkg;

  // Run state of the PWM engine.
  typedef enum logic {
    DISABLED = 1'b0,
    RUN      = 1'b1
  } state_e;

  // Limit a requested high-time to the period length; anything longer means "always high".
  function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input logic [31:0] period);
    return (duty > period) ? period : duty;
  endfunction

endpackage

// File: rtl/edge_tick.sv
// Brings an asynchronous level into the clk domain and flags its rising edges.
module edge_tick (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic tick
);

  logic sync1_q, sync2_q, hist_q;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~hist_q;

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: counts divClk rising edges and drives a duty-controlled waveform.
// New duty values are double-buffered and only take effect at a period boundary.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter  int unsigned PERIOD = 256,
  localparam int unsigned DUTY_W = $clog2(PERIOD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              divClk,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              period_done
);

  localparam logic [DUTY_W-1:0] CntLast = DUTY_W'(PERIOD - 1);
  localparam logic [31:0]       PeriodW = 32'(PERIOD);

  logic tick;

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_active_q, duty_active_d;
  logic [DUTY_W-1:0] pending_q, pending_d;
  logic              pending_full_q, pending_full_d;
  logic              pwm_q, pwm_d;
  logic              period_done_q, period_done_d;

  logic running, wrap, xfer, apply;

  edge_tick u_edge_tick (
    .clk      (clk),
    .rst      (rst),
    .async_in (divClk),
    .tick     (tick)
  );

  // Dropping enable while running aborts the period immediately.
  assign running = (state_q == RUN) && enable;
  assign wrap    = running && tick && (cnt_q == CntLast);
  assign xfer    = duty_valid && !pending_full_q;
  // A value accepted in the wrap clk is not yet pending, so it waits for the next wrap.
  assign apply   = pending_full_q && (wrap || ((state_q == DISABLED) && enable));

  // Next-state for FSM, counter, waveform and duty double-buffer.
  always_comb begin
    state_d        = enable ? RUN : DISABLED;
    cnt_d          = cnt_q;
    duty_active_d  = duty_active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    pwm_d          = running && (cnt_q < duty_active_q);
    period_done_d  = wrap;

    if (!running) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = wrap ? '0 : cnt_q + DUTY_W'(1);
    end

    if (apply) begin
      duty_active_d  = pending_q;
      pending_full_d = 1'b0;
    end

    if (xfer) begin
      pending_d      = DUTY_W'(clamp_duty(32'(duty_in), PeriodW));
      pending_full_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= DISABLED;
      cnt_q          <= '0;
      duty_active_q  <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      pwm_q          <= 1'b0;
      period_done_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      duty_active_q  <= duty_active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      pwm_q          <= pwm_d;
      period_done_q  <= period_done_d;
    end
  end

  assign duty_ready  = !pending_full_q;
  assign pwm_out     = pwm_q;
  assign period_done = period_done_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: directed duty table, multi-cycle corner cases and
// randomized traffic, all compared against a behavioural model.
module tb_pwm_gen;

  localparam int unsigned P = 8;
  localparam int W = $clog2(P + 1);

  logic         clk = 1'b0;
  logic         rst, divClk, enable, duty_valid;
  logic [W-1:0] duty_in;
  logic         duty_ready, pwm_out, period_done;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model state.
  bit m_run, m_pf, m_pwm, m_pd;
  int m_cnt, m_da, m_pend;
  bit div_hist[$];  // divClk as sampled at the most recent edges, newest first
  int div_ph = 0;
  bit div_rand = 0;

  typedef struct {
    int duty;
    int high;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  pwm_gen #(.PERIOD(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .divClk      (divClk),
    .enable      (enable),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
    .period_done (period_done)
  );

  task automatic check_int(input string name, input int got, input int want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One clk: advance the model from the spec rules, then compare all outputs.
  task automatic cyc();
    bit t, run_en, wrap, xfer, apply;
    @(posedge clk);
    div_hist.push_front(divClk);
    void'(div_hist.pop_back());
    // A divClk rise becomes visible after two synchronizer stages.
    t = div_hist[2] && !div_hist[3];
    if (rst) begin
      m_run = 0; m_pf = 0; m_pwm = 0; m_pd = 0; m_cnt = 0; m_da = 0; m_pend = 0;
      foreach (div_hist[i]) div_hist[i] = 0;
    end else begin
      run_en = m_run && enable;
      wrap   = run_en && t && (m_cnt == P - 1);
      xfer   = duty_valid && !m_pf;
      apply  = m_pf && (wrap || (!m_run && enable));
      m_pwm  = run_en && (m_cnt < m_da);
      m_pd   = wrap;
      if (apply) begin
        m_da = m_pend;
        m_pf = 0;
      end
      if (xfer) begin
        m_pend = (int'(duty_in) > P) ? P : int'(duty_in);
        m_pf   = 1;
      end
      if (!run_en) m_cnt = 0;
      else if (t) m_cnt = wrap ? 0 : m_cnt + 1;
      m_run = enable;
    end
    #1;
    tests_run++;
    if ({pwm_out, period_done, duty_ready} !== {m_pwm, m_pd, !m_pf}) begin
      tests_failed++;
      $display("FAIL cycle @%0t: {pwm,done,ready} got %b want %b", $time,
               {pwm_out, period_done, duty_ready}, {m_pwm, m_pd, !m_pf});
    end
    div_ph++;
    divClk = div_rand ? 1'($urandom_range(1)) : ((div_ph % 4) < 2);
  endtask

  task automatic wait_pd(input string name);
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (period_done) return;
    end
    check_int({name, " timeout"}, 0, 1);
  endtask

  // Call when the current cycle is a wrap; accumulates one full period.
  task automatic measure(input int h0, input int l0, output int high, output int len);
    high = h0;
    len  = l0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      len++;
      high += int'(pwm_out);
      if (period_done) return;
    end
    check_int("measure timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; duty_valid = 0; duty_in = '0;
    cyc(); cyc();
    rst = 0;
  endtask

  task automatic load(input int d);
    duty_valid = 1; duty_in = W'(d);
    cyc();
    duty_valid = 0;
  endtask

  initial begin
    int h, l, h2, l2;
    bit stall_ok;
    vt[0] = '{0, 0};
    vt[1] = '{3, 12};
    vt[2] = '{8, 32};
    vt[3] = '{15, 32};
    vt[4] = '{1, 4};
    vt[5] = '{7, 28};
    div_hist = '{0, 0, 0, 0};
    divClk = 0;

    do_reset();
    check_int("reset outputs", int'({pwm_out, period_done, duty_ready}), 3'b001);

    // Duty table: each cnt value lasts 4 clk with this divClk, so a period is 32 clk.
    foreach (vt[k]) begin
      do_reset();
      load(vt[k].duty);
      check_int("ready after load", int'(duty_ready), 0);
      enable = 1;
      wait_pd("table");
      measure(0, 0, h, l);
      measure(0, 0, h2, l2);
      check_int($sformatf("high d%0d", vt[k].duty), h, vt[k].high);
      check_int($sformatf("high2 d%0d", vt[k].duty), h2, vt[k].high);
      check_int($sformatf("len d%0d", vt[k].duty), l, 32);
    end

    // Two offers mid-period: the second stalls until the wrap that applies the first.
    do_reset();
    load(3);
    enable = 1;
    wait_pd("seq1");
    for (int i = 0; i < 10; i++) cyc();
    duty_valid = 1; duty_in = W'(2);
    cyc();
    check_int("ready after first xfer", int'(duty_ready), 0);
    duty_in = W'(6);
    stall_ok = 1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (period_done) break;
      if (duty_ready) stall_ok = 0;
    end
    check_int("stall until wrap", int'(stall_ok), 1);
    check_int("ready at wrap", int'(duty_ready), 1);
    cyc();
    check_int("ready after second xfer", int'(duty_ready), 0);
    duty_valid = 0;
    measure(int'(pwm_out), 1, h, l);
    check_int("period with 2", h, 8);
    measure(0, 0, h, l);
    check_int("period with 6", h, 24);

    // Transfer coinciding with a wrap waits one more period.
    do_reset();
    load(3);
    enable = 1;
    wait_pd("seq2");
    for (int i = 0; i < 200; i++) begin
      if (m_run && enable && div_hist[1] && !div_hist[2] && m_cnt == P - 1) break;
      cyc();
    end
    duty_valid = 1; duty_in = W'(5);
    cyc();
    check_int("wrap with xfer", int'({period_done, duty_ready}), 2'b10);
    duty_valid = 0;
    measure(0, 0, h, l);
    check_int("old duty kept", h, 12);
    measure(0, 0, h, l);
    check_int("new duty 5", h, 20);

    // Reset mid-period with a pending value.
    do_reset();
    load(3);
    enable = 1;
    wait_pd("seq3");
    load(6);
    for (int i = 0; i < 200 && m_cnt != 4; i++) cyc();
    check_int("pending before rst", int'(duty_ready), 0);
    rst = 1;
    cyc();
    check_int("rst mid-period", int'({pwm_out, period_done, duty_ready}), 3'b001);
    rst = 0;

    // Enable drop at cnt 5 and restart with the retained duty.
    do_reset();
    load(7);
    enable = 1;
    wait_pd("seq4");
    for (int i = 0; i < 200 && m_cnt != 5; i++) cyc();
    enable = 0;
    cyc();
    check_int("pwm after disable", int'(pwm_out), 0);
    for (int i = 0; i < 5; i++) cyc();
    enable = 1;
    wait_pd("seq4b");
    measure(0, 0, h, l);
    check_int("retained duty 7", h, 28);

    // Randomized traffic against the model.
    div_rand = 1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(299) == 0);
      duty_valid = ($urandom_range(7) == 0);
      duty_in    = W'($urandom_range(15));
      if ($urandom_range(49) == 0) enable = ~enable;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
